// File: rtl/datamem_arbiter_if.sv
// Bundle of both requester ports and the data-memory side of the datamem arbiter.
// The arbiter uses the slave view; requesters plus memory model use the master view.
interface datamem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_waddr, mem_raddr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_waddr, mem_raddr, mem_wdata
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port arbiter for the single-ported data memory: port 0 has fixed priority,
// port 1 is forced through after MAX_WAIT consecutive lost arbitrations.
module datamem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  datamem_arbiter_if.slave       bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_e            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic              sel_q, sel_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
  logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              any_req, win1;

  assign any_req = bus.p0_req | bus.p1_req;
  // Port 1 wins when alone, or when it has been starved long enough.
  assign win1    = bus.p1_req & (~bus.p0_req | (wait_cnt == CNT_W'(MAX_WAIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    sel_d       = sel_q;
    wait_cnt_d  = wait_cnt;
    p0_gnt_d    = 1'b0;
    p1_gnt_d    = 1'b0;
    p0_rvalid_d = 1'b0;
    p1_rvalid_d = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    mem_en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d       = win1;
          acc_d.we    = win1 ? bus.p1_we    : bus.p0_we;
          acc_d.addr  = win1 ? bus.p1_addr  : bus.p0_addr;
          acc_d.wdata = win1 ? bus.p1_wdata : bus.p0_wdata;
          p0_gnt_d    = ~win1;
          p1_gnt_d    = win1;
          mem_en_d    = acc_d.we;
        end
        // Reaching this else-if implies both ports requested and port 0 won.
        if (!bus.p1_req || win1) begin
          wait_cnt_d = '0;
        end else if (wait_cnt < CNT_W'(MAX_WAIT)) begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (!acc_q.we) begin
          if (sel_q) begin
            p1_rvalid_d = 1'b1;
            p1_rdata_d  = bus.mem_rdata;
          end else begin
            p0_rvalid_d = 1'b1;
            p0_rdata_d  = bus.mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Async reset also kills an in-flight mem_en so the write never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sel_q       <= 1'b0;
      wait_cnt    <= '0;
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sel_q       <= sel_d;
      wait_cnt    <= wait_cnt_d;
      p0_gnt_q    <= p0_gnt_d;
      p1_gnt_q    <= p1_gnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      mem_en_q    <= mem_en_d;
    end
  end

  assign bus.p0_gnt    = p0_gnt_q;
  assign bus.p1_gnt    = p1_gnt_q;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_waddr = acc_q.addr;
  assign bus.mem_raddr = acc_q.addr;
  assign bus.mem_wdata = acc_q.wdata;
endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter: vector table of single accesses,
// hand sequences for contention, starvation, withdrawal and reset mid-access.
module tb_datamem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datamem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  datamem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_raddr];
  always @(posedge clk) if (bus.mem_en) mem[bus.mem_waddr] <= bus.mem_wdata;

  typedef struct {
    logic       port;
    logic [7:0] data;
  } exp_t;
  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 7 + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic port, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  // Scoreboard: every rvalid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (bus.p0_rvalid || bus.p1_rvalid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected: got p0=%b p1=%b want none", bus.p0_rvalid, bus.p1_rvalid);
      end else begin
        mon_e = sbq.pop_front();
        check("rvalid_port", {bus.p1_rvalid, bus.p0_rvalid}, mon_e.port ? 2'b10 : 2'b01);
        check("rdata", mon_e.port ? bus.p1_rdata : bus.p0_rdata, mon_e.data);
      end
    end
  end

  task automatic single_access(input vec_t v);
    int   n;
    logic got;
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
    if (!v.we) sbq.push_back('{port: v.port, data: v.rdata});
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = v.port ? bus.p1_gnt : bus.p0_gnt;
    end
    check("gnt_latency", n, 1);
    check("other_gnt", v.port ? bus.p0_gnt : bus.p1_gnt, 0);
    check("mem_en_access", bus.mem_en, v.we);
    check("mem_raddr", bus.mem_raddr, v.addr);
    check("mem_waddr", bus.mem_waddr, v.addr);
    if (v.we) check("mem_wdata", bus.mem_wdata, v.wdata);
    set_req(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("mem_en_idle", bus.mem_en, 0);
    check("gnt_pulse", v.port ? bus.p1_gnt : bus.p0_gnt, 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, rdata: 8'h5A};
    vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'hC3, rdata: 8'h00};
    vecs[2] = '{port: 1'b1, we: 1'b0, addr: 8'h20, wdata: 8'h00, rdata: 8'hC3};
    vecs[3] = '{port: 1'b0, we: 1'b1, addr: 8'h40, wdata: 8'hA5, rdata: 8'h00};
    vecs[4] = '{port: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, rdata: 8'h01};
    vecs[5] = '{port: 1'b1, we: 1'b0, addr: 8'h40, wdata: 8'h00, rdata: 8'hA5};

    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    mem[8'h10] = 8'h5A;
    mem[8'h30] = 8'h77;
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_p0_gnt", bus.p0_gnt, 0);
    check("rst_p1_gnt", bus.p1_gnt, 0);
    check("rst_p0_rvalid", bus.p0_rvalid, 0);
    check("rst_p1_rvalid", bus.p1_rvalid, 0);
    check("rst_p0_rdata", bus.p0_rdata, 0);
    check("rst_p1_rdata", bus.p1_rdata, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_waddr", bus.mem_waddr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_wait_cnt", dut.wait_cnt, 0);

    for (int i = 0; i < 6; i++) single_access(vecs[i]);
    check("p0_rdata_held", bus.p0_rdata, 8'h01);
    check("mem40_written", mem[8'h40], 8'hA5);

    // Simultaneous reads: p0 first, p1 at the following IDLE edge
    sbq.push_back('{port: 1'b0, data: init_val(1)});
    sbq.push_back('{port: 1'b1, data: init_val(2)});
    set_req(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
    @(negedge clk);
    check("sim_p0_gnt", bus.p0_gnt, 1);
    check("sim_p1_gnt_lost", bus.p1_gnt, 0);
    check("sim_raddr0", bus.mem_raddr, 8'h01);
    check("sim_wait1", dut.wait_cnt, 1);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("sim_p1_gnt_idle", bus.p1_gnt, 0);
    @(negedge clk);
    check("sim_p1_gnt", bus.p1_gnt, 1);
    check("sim_raddr1", bus.mem_raddr, 8'h02);
    check("sim_wait0", dut.wait_cnt, 0);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Starvation: p0 back-to-back, p1 held; p1 must win the 5th arbitration
    for (int i = 0; i < 4; i++) sbq.push_back('{port: 1'b0, data: init_val(3)});
    sbq.push_back('{port: 1'b1, data: init_val(4)});
    set_req(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 8'h04, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("starve_p0_gnt", bus.p0_gnt, (i < 4) ? 1 : 0);
      check("starve_p1_gnt", bus.p1_gnt, (i == 4) ? 1 : 0);
      check("starve_wait_cnt", dut.wait_cnt, (i < 4) ? i + 1 : 0);
      if (i == 4) begin
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      @(negedge clk);
    end
    @(negedge clk);

    // p1 withdraws while p0 is being served
    sbq.push_back('{port: 1'b0, data: init_val(5)});
    set_req(1'b0, 1'b1, 1'b0, 8'h05, 8'h00);
    set_req(1'b1, 1'b1, 1'b1, 8'h06, 8'hEE);
    @(negedge clk);
    check("wd_p0_gnt", bus.p0_gnt, 1);
    check("wd_p1_gnt", bus.p1_gnt, 0);
    check("wd_wait1", dut.wait_cnt, 1);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("wd_wait_cleared", dut.wait_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      check("wd_no_p1_gnt", bus.p1_gnt, 0);
      check("wd_no_mem_en", bus.mem_en, 0);
      @(negedge clk);
    end
    check("wd_mem06", mem[8'h06], init_val(6));

    // Reset in the middle of a p0 write access
    set_req(1'b0, 1'b1, 1'b1, 8'h30, 8'hFF);
    @(negedge clk);
    check("rstw_gnt", bus.p0_gnt, 1);
    check("rstw_mem_en", bus.mem_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_mem_en_async", bus.mem_en, 0);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rstw_mem30", mem[8'h30], 8'h77);
    check("rstw_p0_gnt", bus.p0_gnt, 0);
    check("rstw_p0_rvalid", bus.p0_rvalid, 0);
    check("rstw_p0_rdata", bus.p0_rdata, 0);
    check("rstw_p1_rdata", bus.p1_rdata, 0);
    check("rstw_mem_waddr", bus.mem_waddr, 0);
    check("rstw_mem_raddr", bus.mem_raddr, 0);
    check("rstw_mem_wdata", bus.mem_wdata, 0);
    check("rstw_wait_cnt", dut.wait_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstw_mem30_after", mem[8'h30], 8'h77);
    check("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter that shares the single-ported 8-bit data memory (`datamem`) between the core load/store unit (port 0) and the data loader/debug port (port 1). It accepts one request at a time, latches it, drives the memory's enable/address/data lines for exactly one access cycle, and returns read data to the winning port with a one-cycle valid pulse. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.

## Interface
Parameters:
- `ADDR_W`, 8: address width (memory has 2^ADDR_W words).
- `DATA_W`, 8: data word width.
- `MAX_WAIT`, 4: consecutive lost arbitrations after which port 1 is forced to win (legal range 1..15).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `p0_req`, `p1_req` input 1: access request; held until grant or withdrawn.
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read; stable while req is high.
- `p0_addr`, `p1_addr` input ADDR_W: access address.
- `p0_wdata`, `p1_wdata` input DATA_W: write data.
- `p0_gnt`, `p1_gnt` output 1: one-cycle pulse; request accepted.
- `p0_rvalid`, `p1_rvalid` output 1: one-cycle pulse; `pX_rdata` holds read result.
- `p0_rdata`, `p1_rdata` output DATA_W: last read result for that port; held until that port's next read.
- `mem_en` output 1: memory write enable.
- `mem_waddr`, `mem_raddr` output ADDR_W: memory write/read address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory combinational read data (valid in the same cycle as `mem_raddr`).

## Operation
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- IDLE, no req: stay in IDLE. All outputs except held `rdata` are low or held.
- IDLE, any req sampled at the edge:
  - Select a winner.
  - Latch its `we`, `addr` and `wdata` into the access register.
  - Set `sel` and the winner's `gnt` for the next cycle.
  - Go to ACCESS.
- Winner selection:
  - Only one req: that port wins.
  - Both req and `wait_cnt == MAX_WAIT`: port 1 wins.
  - Otherwise both req: port 0 wins.
- `wait_cnt`, width 4, reset 0:
  - +1 at each IDLE edge where both req are high and port 0 wins.
  - Cleared when port 1 is granted, or at any IDLE edge with `p1_req` low.
  - Saturates at MAX_WAIT.
- ACCESS (exactly one cycle):
  - Drive `mem_waddr` = `mem_raddr` = latched addr, and `mem_wdata` = latched wdata.
  - `mem_en` = latched we.
  - Read: at the closing edge, capture `mem_rdata` into `pX_rdata` and pulse `pX_rvalid` in the next cycle.
  - Write: no rvalid.
  - Always returns to IDLE.
- Arbitration is performed only in IDLE. Req levels during ACCESS are ignored.
- A requester drops req in its gnt cycle for a single access. If req is still high at the next IDLE edge, it is a new request (back-to-back is legal).
- A requester may withdraw req before gnt; nothing is latched.
- Memory address/data outputs hold their last values in IDLE. `mem_en` is 0 outside ACCESS.

## Timing
- Request sampled at edge E (IDLE).
- `gnt` and ACCESS in cycle E+1.
- `mem_en` for a write is high in E+1; the memory commits at edge E+2.
- `rvalid`/`rdata` are visible in cycle E+2, which is also IDLE, so a new arbitration occurs at edge E+2.
- Peak throughput is one access per 2 cycles.
- Reset values: state IDLE, `gnt` 0, `rvalid` 0, `rdata` 0, `mem_en` 0, mem addresses/data 0, `wait_cnt` 0, access register 0.
- Reset asserted during ACCESS:
  - `mem_en` drops immediately (asynchronously), so the write does not commit.
  - No rvalid is issued.
  - The request is lost; the requester must re-request after reset.
- Simultaneous req with `wait_cnt < MAX_WAIT`: port 0 always wins.
- Port 1 is granted within MAX_WAIT+1 arbitrations of continuous request.

## Test plan
- Reset, then port 0 reads addr 0x10 (mem[0x10]=0x5A): `p0_gnt` in E+1, `mem_raddr`=0x10 in E+1, `p0_rvalid`=1 with `p0_rdata`=0x5A in E+2, `p1_*` quiet.
- Port 1 writes 0xC3 to 0x20, then reads 0x20: `mem_en`=1 only in the write's ACCESS cycle, `mem_waddr`=0x20, `mem_wdata`=0xC3. The read returns `p1_rdata`=0xC3.
- Simultaneous requests (p0 read 0x01, p1 read 0x02): p0 is granted first. p1 is granted at the next IDLE edge after p0 drops req. Each rdata is correct and only the matching rvalid pulses.
- Starvation, MAX_WAIT=4: p0 requests back-to-back continuously while p1 holds a request. p0 wins 4 arbitrations, p1 wins the 5th, and `wait_cnt` returns to 0.
- `rst_n` low mid-ACCESS of a p0 write of 0xFF to 0x30: `mem_en` drops immediately, mem[0x30] is unchanged, and all outputs take their reset values.
- p1 raises req and withdraws it before its grant (p0 busy): no `p1_gnt`, no memory access for p1, and `wait_cnt` cleared.
